lc3_mem_server: RTL and testbench
=================================

# lc3_mem_server

Parametrised, synthesizable dual-channel memory responder for the LC3 core's instruction and data buses. It replaces the ad-hoc memory behaviour in the LC3 verification bench with a block that has:
- configurable depth, widths and per-channel wait states;
- an explicit request/complete handshake on each channel;
- a bench preload port.

It sits beside the LC3 DUT in the top-level bench, with ports wired name-for-name to the DUT's memory pins.

## Interface
- ADDR_W, 16, address width of pc / Data_addr / load_addr
- DATA_W, 16, word width
- DEPTH, 256, words of storage; power of two, ≤ 2**ADDR_W
- INSTR_LAT, 1, instruction wait states, 0..15
- DATA_LAT, 2, data wait states, 0..15

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- pc  in  ADDR_W  instruction fetch address
- instrmem_rd  in  1  instruction fetch request
- Instr_dout  out  DATA_W  fetched instruction
- complete_instr  out  1  one-cycle fetch-done pulse
- Data_addr  in  ADDR_W  data access address
- data_req  in  1  data access request
- Data_rd  in  1  1 = read, 0 = write; sampled with data_req
- Data_dout  in  DATA_W  write data from DUT; sampled with data_req
- Data_din  out  DATA_W  read data to DUT
- complete_data  out  1  one-cycle data-done pulse
- load_en  in  1  bench preload write strobe
- load_addr  in  ADDR_W  preload address
- load_data  in  DATA_W  preload data

## Operation
- Two independent channel FSMs (instruction, data), each with states IDLE → WAIT → DONE → IDLE.
- IDLE:
  - request high at an edge captures address, and for data also Data_rd / Data_dout.
  - If LAT = 0, go to DONE; otherwise go to WAIT with counter = LAT.
- WAIT: counter decrements each cycle; at 1, go to DONE.
- DONE: complete_* high for exactly one cycle; access performed this cycle; return to IDLE.
- Requests in WAIT/DONE are ignored; a request still high in the IDLE cycle after DONE starts a new access.
- Read: Instr_dout / Data_din load mem[addr] on the DONE edge, then hold until the next completion of that channel.
- Write: mem[addr] ← captured Data_dout on the DONE edge; Data_din unchanged.
- Index = address mod DEPTH (low log2(DEPTH) bits).
- Single memory write port; load_en has priority.
  - A data write reaching DONE while load_en is high stays in DONE one extra cycle.
  - complete_data is then delayed one cycle and the write commits on the retry.
- Read-before-write: instruction fetch completing on the same edge as a data write to the same index returns the old word.
- Memory contents are not cleared by reset; they persist across reset.

## Timing
- Request sampled at edge N → complete_* high during cycle N+1+LAT; data valid in the same cycle.
- Back-to-back throughput per channel: one access per LAT+2 cycles.
- Channels run concurrently; simultaneous fetch and data access never stall each other, except the load_en conflict above.
- Reset values: Instr_dout = 0, Data_din = 0, complete_instr = 0, complete_data = 0, both FSMs IDLE, counters 0.
- Reset mid-access: access aborted, no write commits, no complete pulse.
- load_en write visible to reads completing on the following edge or later.

## Configuration
- LC3_MEM_OOR_EN defined:
  - adds port mem_err (out, 1, reset 0).
  - Any channel or load address ≥ DEPTH performs no access: reads return 0, writes are dropped.
  - complete_* still pulses on schedule.
  - mem_err sets on that DONE edge and stays sticky until reset.
- LC3_MEM_OOR_EN undefined: no mem_err port; all addresses wrap mod DEPTH.

## Test plan
- Preload mem[0x10] = 0x1234 via load_en; instrmem_rd with pc = 0x10, INSTR_LAT = 1 → complete_instr pulses 2 cycles after request, Instr_dout = 0x1234.
- Data write 0xBEEF to 0x20, DATA_LAT = 2, then data read of 0x20 → complete_data 3 cycles after each request; read returns Data_din = 0xBEEF.
- Fetch 0x20 and write 0xCAFE to 0x20 completing on the same edge → Instr_dout = old value (0xBEEF); a later fetch returns 0xCAFE.
- load_en to 0x30 on the cycle a data write to 0x31 reaches DONE → complete_data delayed one cycle; both words stored correctly.
- Assert reset during WAIT of a write to 0x40 (old value 0x0001) → no complete_data; mem[0x40] still 0x0001; all outputs 0.
- With LC3_MEM_OOR_EN and DEPTH = 256: read of 0x0100 → complete_data on schedule, Data_din = 0, mem_err = 1 until reset.

Source files
------------

// File: rtl/lc3_mem_server.sv
// Dual-channel (instruction/data) memory responder for the LC3 bench, with wait states and a preload port.
// Optional feature: define LC3_MEM_OOR_EN to add mem_err and out-of-range access suppression.
module lc3_mem_server #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 256,
  parameter int INSTR_LAT = 1,
  parameter int DATA_LAT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instrmem_rd,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [DATA_W-1:0] Data_dout,
  output logic [DATA_W-1:0] Data_din,
  output logic              complete_data,
`ifdef LC3_MEM_OOR_EN
  output logic              mem_err,
`endif
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] ILAT = 4'(INSTR_LAT);
  localparam logic [3:0] DLAT = 4'(DATA_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            istate_r, istate_s;
  logic [3:0]        icnt_r, icnt_s;
  logic [ADDR_W-1:0] iaddr_r, iaddr_s;
  logic              idone_s;

  state_t            dstate_r, dstate_s;
  logic [3:0]        dcnt_r, dcnt_s;
  logic [ADDR_W-1:0] daddr_r, daddr_s;
  logic              drd_r, drd_s;
  logic [DATA_W-1:0] dwdata_r, dwdata_s;
  logic              ddone_s;
  logic              dwr_s;

  logic              i_inr_s, d_inr_s, load_inr_s;
  logic [IDX_W-1:0]  iidx_s, didx_s, lidx_s;
  logic              unused_s;

  assign iidx_s = iaddr_r[IDX_W-1:0];
  assign didx_s = daddr_r[IDX_W-1:0];
  assign lidx_s = load_addr[IDX_W-1:0];
  // upper address bits are deliberately ignored when addresses wrap
  assign unused_s = ^{iaddr_r, daddr_r, load_addr};

`ifdef LC3_MEM_OOR_EN
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  assign i_inr_s    = in_range(iaddr_r);
  assign d_inr_s    = in_range(daddr_r);
  assign load_inr_s = in_range(load_addr);
`else
  assign i_inr_s    = 1'b1;
  assign d_inr_s    = 1'b1;
  assign load_inr_s = 1'b1;
`endif

  // Instruction channel next-state logic
  always_comb begin
    istate_s = istate_r;
    icnt_s   = icnt_r;
    iaddr_s  = iaddr_r;
    idone_s  = 1'b0;
    case (istate_r)
      ST_IDLE: begin
        if (instrmem_rd) begin
          iaddr_s = pc;
          if (ILAT == 4'd0) begin
            istate_s = ST_DONE;
          end else begin
            istate_s = ST_WAIT;
            icnt_s   = ILAT;
          end
        end else begin
          istate_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (icnt_r <= 4'd1) begin
          istate_s = ST_DONE;
          icnt_s   = 4'd0;
        end else begin
          icnt_s = icnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        idone_s  = 1'b1;
        istate_s = ST_IDLE;
      end
      default: begin
        istate_s = ST_IDLE;
        icnt_s   = 4'd0;
      end
    endcase
  end

  // Data channel next-state logic; a write yields the memory port to load_en by lingering in DONE
  always_comb begin
    dstate_s = dstate_r;
    dcnt_s   = dcnt_r;
    daddr_s  = daddr_r;
    drd_s    = drd_r;
    dwdata_s = dwdata_r;
    ddone_s  = 1'b0;
    case (dstate_r)
      ST_IDLE: begin
        if (data_req) begin
          daddr_s  = Data_addr;
          drd_s    = Data_rd;
          dwdata_s = Data_dout;
          if (DLAT == 4'd0) begin
            dstate_s = ST_DONE;
          end else begin
            dstate_s = ST_WAIT;
            dcnt_s   = DLAT;
          end
        end else begin
          dstate_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dcnt_r <= 4'd1) begin
          dstate_s = ST_DONE;
          dcnt_s   = 4'd0;
        end else begin
          dcnt_s = dcnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        if (!drd_r && load_en) begin
          dstate_s = ST_DONE;
        end else begin
          ddone_s  = 1'b1;
          dstate_s = ST_IDLE;
        end
      end
      default: begin
        dstate_s = ST_IDLE;
        dcnt_s   = 4'd0;
      end
    endcase
  end

  assign dwr_s = ddone_s && !drd_r && d_inr_s;

  // Channel state registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      istate_r <= ST_IDLE;
      icnt_r   <= 4'd0;
      iaddr_r  <= '0;
      dstate_r <= ST_IDLE;
      dcnt_r   <= 4'd0;
      daddr_r  <= '0;
      drd_r    <= 1'b0;
      dwdata_r <= '0;
    end else begin
      istate_r <= istate_s;
      icnt_r   <= icnt_s;
      iaddr_r  <= iaddr_s;
      dstate_r <= dstate_s;
      dcnt_r   <= dcnt_s;
      daddr_r  <= daddr_s;
      drd_r    <= drd_s;
      dwdata_r <= dwdata_s;
    end
  end

  // Single memory write port, never cleared; preload wins over a committing data write
  always_ff @(posedge clock) begin
    if (load_en) begin
      if (load_inr_s) begin
        mem_r[lidx_s] <= load_data;
      end
    end else if (dwr_s && reset) begin
      mem_r[didx_s] <= dwdata_r;
    end
  end

  // Registered completion pulses and read data (reads see the pre-write word on a same-edge write)
  always_ff @(posedge clock) begin
    if (!reset) begin
      Instr_dout     <= '0;
      Data_din       <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
`ifdef LC3_MEM_OOR_EN
      mem_err        <= 1'b0;
`endif
    end else begin
      complete_instr <= idone_s;
      complete_data  <= ddone_s;
      if (idone_s) begin
        Instr_dout <= i_inr_s ? mem_r[iidx_s] : '0;
      end
      if (ddone_s && drd_r) begin
        Data_din <= d_inr_s ? mem_r[didx_s] : '0;
      end
`ifdef LC3_MEM_OOR_EN
      mem_err <= mem_err | (idone_s & ~i_inr_s) | (ddone_s & ~d_inr_s) | (load_en & ~load_inr_s);
`endif
    end
  end

endmodule

// File: tb/tb_lc3_mem_server.sv
// Directed self-checking bench for lc3_mem_server (INSTR_LAT=1, DATA_LAT=2, DEPTH=256).
module tb_lc3_mem_server;

  localparam int INSTR_LAT = 1;
  localparam int DATA_LAT  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic [15:0] Data_addr;
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_dout;
  logic [15:0] Data_din;
  logic        complete_data;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
`ifdef LC3_MEM_OOR_EN
  logic        mem_err;
`endif

  int checks = 0;
  int errors = 0;

  lc3_mem_server #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(256),
    .INSTR_LAT(INSTR_LAT), .DATA_LAT(DATA_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc(pc),
    .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout),
    .complete_instr(complete_instr),
    .Data_addr(Data_addr),
    .data_req(data_req),
    .Data_rd(Data_rd),
    .Data_dout(Data_dout),
    .Data_din(Data_din),
    .complete_data(complete_data),
`ifdef LC3_MEM_OOR_EN
    .mem_err(mem_err),
`endif
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [15:0] addr, input logic [15:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    tick;
    load_en = 1'b0;
  endtask

  // exp is the expected Data_din after completion (held value for writes)
  task automatic data_op(input string tag, input logic [15:0] addr, input logic rd,
                         input logic [15:0] wd, input logic [15:0] exp);
    Data_addr = addr; Data_rd = rd; Data_dout = wd; data_req = 1'b1;
    tick;
    data_req = 1'b0;
    for (int i = 0; i < DATA_LAT; i++) begin
      tick;
      check_eq({tag, "_early"}, 16'(complete_data), 16'd0);
    end
    tick;
    check_eq({tag, "_done"}, 16'(complete_data), 16'd1);
    check_eq({tag, "_din"}, Data_din, exp);
  endtask

  task automatic fetch_op(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    pc = addr; instrmem_rd = 1'b1;
    tick;
    instrmem_rd = 1'b0;
    for (int i = 0; i < INSTR_LAT; i++) begin
      tick;
      check_eq({tag, "_early"}, 16'(complete_instr), 16'd0);
    end
    tick;
    check_eq({tag, "_done"}, 16'(complete_instr), 16'd1);
    check_eq({tag, "_dout"}, Instr_dout, exp);
  endtask

  initial begin
    reset = 1'b0; pc = 16'h0000; instrmem_rd = 1'b0;
    Data_addr = 16'h0000; data_req = 1'b0; Data_rd = 1'b0; Data_dout = 16'h0000;
    load_en = 1'b0; load_addr = 16'h0000; load_data = 16'h0000;
    tick;
    tick;
    check_eq("rst_idout", Instr_dout, 16'h0000);
    check_eq("rst_ddin", Data_din, 16'h0000);
    check_eq("rst_ci", 16'(complete_instr), 16'd0);
    check_eq("rst_cd", 16'(complete_data), 16'd0);
`ifdef LC3_MEM_OOR_EN
    check_eq("rst_err", 16'(mem_err), 16'd0);
`endif
    reset = 1'b1;
    preload(16'h0010, 16'h1234);
    preload(16'h0040, 16'h0001);

    fetch_op("f10", 16'h0010, 16'h1234);
    tick;
    check_eq("f10_pulse1", 16'(complete_instr), 16'd0);
    check_eq("f10_hold", Instr_dout, 16'h1234);

    data_op("w20", 16'h0020, 1'b0, 16'hBEEF, 16'h0000);
    tick;
    check_eq("w20_pulse1", 16'(complete_data), 16'd0);
    data_op("r20", 16'h0020, 1'b1, 16'h0000, 16'hBEEF);

    // write 0xCAFE and fetch the same word, both completing on one edge
    Data_addr = 16'h0020; Data_rd = 1'b0; Data_dout = 16'hCAFE; data_req = 1'b1;
    tick;
    data_req = 1'b0; pc = 16'h0020; instrmem_rd = 1'b1;
    tick;
    instrmem_rd = 1'b0;
    tick;
    check_eq("rbw_ci_early", 16'(complete_instr), 16'd0);
    check_eq("rbw_cd_early", 16'(complete_data), 16'd0);
    tick;
    check_eq("rbw_ci", 16'(complete_instr), 16'd1);
    check_eq("rbw_cd", 16'(complete_data), 16'd1);
    check_eq("rbw_old", Instr_dout, 16'hBEEF);
    check_eq("rbw_din", Data_din, 16'hBEEF);
    fetch_op("f20_new", 16'h0020, 16'hCAFE);

    // preload collides with a data write sitting in DONE
    Data_addr = 16'h0031; Data_rd = 1'b0; Data_dout = 16'h6666; data_req = 1'b1;
    tick;
    data_req = 1'b0;
    tick;
    tick;
    load_en = 1'b1; load_addr = 16'h0030; load_data = 16'h5555;
    tick;
    load_en = 1'b0;
    check_eq("coll_delay", 16'(complete_data), 16'd0);
    tick;
    check_eq("coll_done", 16'(complete_data), 16'd1);
    tick;
    check_eq("coll_pulse1", 16'(complete_data), 16'd0);
    data_op("r30", 16'h0030, 1'b1, 16'h0000, 16'h5555);
    data_op("r31", 16'h0031, 1'b1, 16'h0000, 16'h6666);

    // back-to-back fetches with request held high: one per INSTR_LAT+2 cycles
    pc = 16'h0010; instrmem_rd = 1'b1;
    tick;
    tick;
    check_eq("b2b_a_early", 16'(complete_instr), 16'd0);
    tick;
    check_eq("b2b_a_done", 16'(complete_instr), 16'd1);
    check_eq("b2b_a_dout", Instr_dout, 16'h1234);
    pc = 16'h0030;
    tick;
    check_eq("b2b_gap1", 16'(complete_instr), 16'd0);
    tick;
    check_eq("b2b_gap2", 16'(complete_instr), 16'd0);
    instrmem_rd = 1'b0;
    tick;
    check_eq("b2b_b_done", 16'(complete_instr), 16'd1);
    check_eq("b2b_b_dout", Instr_dout, 16'h5555);

    // reset during WAIT of a write aborts it
    Data_addr = 16'h0040; Data_rd = 1'b0; Data_dout = 16'h9999; data_req = 1'b1;
    tick;
    data_req = 1'b0; reset = 1'b0;
    tick;
    tick;
    check_eq("abort_cd", 16'(complete_data), 16'd0);
    check_eq("abort_ci", 16'(complete_instr), 16'd0);
    check_eq("abort_idout", Instr_dout, 16'h0000);
    check_eq("abort_ddin", Data_din, 16'h0000);
    reset = 1'b1;
    tick;
    tick;
    tick;
    check_eq("abort_nopulse", 16'(complete_data), 16'd0);
    data_op("r40", 16'h0040, 1'b1, 16'h0000, 16'h0001);

`ifdef LC3_MEM_OOR_EN
    check_eq("oor_err_pre", 16'(mem_err), 16'd0);
    data_op("oor_r100", 16'h0100, 1'b1, 16'h0000, 16'h0000);
    check_eq("oor_err_set", 16'(mem_err), 16'd1);
    tick;
    check_eq("oor_err_sticky", 16'(mem_err), 16'd1);
    reset = 1'b0;
    tick;
    check_eq("oor_err_rst", 16'(mem_err), 16'd0);
    reset = 1'b1;
`else
    data_op("wrap_r120", 16'h0120, 1'b1, 16'h0000, 16'hCAFE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
